pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised program-counter unit for the RISC-V fetch stage; successor to the plain PC register.
- Selects the next PC from five sources by fixed priority:
  - sequential increment
  - branch target
  - JALR target
  - trap vector
  - return-from-trap (EPC)
- Adds stall hold, target-alignment checking, an internal EPC register and a one-cycle redirect pulse that tells fetch/decode to flush.

Parameters:
- WIDTH, 32: PC and target width in bits.
- RESET_VECTOR, 32'h0000_0000: PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100: PC value loaded on trap or misaligned target.
- ALIGN_BITS, 2: log2 of instruction alignment in bytes.
  - 2 = 4-byte (RV32I); 1 = 2-byte (C extension).
  - Sequential step is (1 << ALIGN_BITS).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hold PC for this cycle (sequential update suppressed).
- branch_taken  input  1  conditional branch resolved taken.
- branch_target  input  WIDTH  branch destination.
- jalr  input  1  JALR executing.
- jalr_target  input  WIDTH  rs1+imm; bit 0 is cleared internally.
- trap  input  1  exception/interrupt request.
- mret  input  1  return from trap.
- pc  output  WIDTH  current PC (registered).
- pc_next_seq  output  WIDTH  pc + (1<<ALIGN_BITS), combinational; used for the link value.
- epc  output  WIDTH  saved exception PC (registered).
- misaligned  output  1  one-cycle pulse: last accepted redirect target was misaligned.
- redirect  output  1  one-cycle pulse: PC was loaded non-sequentially on the previous edge.

Behaviour:
- Reset (asynchronous, any time, including mid-stall or mid-redirect):
  - pc = RESET_VECTOR, epc = 0, misaligned = 0, redirect = 0.
  - Reset dominates every input.
- Per rising edge, with reset low, the first matching rule applies:
  1. trap: epc <= pc; pc <= TRAP_VECTOR; redirect <= 1.
  2. mret: pc <= epc; redirect <= 1.
  3. jalr: the target is T = jalr_target with bit 0 forced to 0.
  4. branch_taken: the target is T = branch_target.
  5. stall: pc holds; redirect <= 0.
  6. Otherwise: pc <= pc + (1<<ALIGN_BITS); redirect <= 0.
- Target handling for rules 3 and 4:
  - If T[ALIGN_BITS-1:0] == 0: pc <= T; redirect <= 1.
  - Else (misaligned): epc <= pc; pc <= TRAP_VECTOR; misaligned <= 1; redirect <= 1.
  - With ALIGN_BITS = 1 the JALR bit-0 clear means a JALR target can never be misaligned.
- misaligned is 0 on every edge that does not take the misaligned path.
- Stall versus redirects:
  - trap, mret, jalr and branch_taken all override stall.
  - A redirect taken while stall is high is not lost.
- Simultaneous requests:
  - trap + mret: trap wins, and epc captures the current pc, not the old epc.
  - jalr + branch_taken: jalr wins.
- Arithmetic:
  - The sequential add is modulo 2^WIDTH: pc = all-ones minus step + 1 wraps to 0.
  - No carry-out and no overflow flag.
- epc changes only on trap or on the misaligned path; mret does not modify it.
- Latency:
  - pc reflects a selection one edge after the request is sampled.
  - redirect and misaligned assert in that same cycle, for exactly one cycle unless another redirect follows.

Test Plan:
- Reset and sequential:
  - Stimulus: reset high then released; 3 idle edges.
  - Required: pc = 0x0 during reset, then 0x4, 0x8, 0xC; redirect stays 0.
- Stall and branch:
  - Stimulus: from pc = 0x10, stall held 2 edges, then branch_taken with branch_target = 0x40 while stall is still high.
  - Required: pc holds at 0x10 for 2 edges, then becomes 0x40 with a redirect pulse; the next edge without stall gives 0x44.
- JALR bit-0 clear and misalignment:
  - Stimulus 1: jalr_target = 0x81.
  - Required: pc = 0x80, misaligned = 0.
  - Stimulus 2: from pc = 0x80, jalr_target = 0x82 (ALIGN_BITS = 2).
  - Required: pc = 0x100, epc = 0x80, misaligned and redirect each pulse for 1 cycle.
- Trap and return:
  - Stimulus: at pc = 0x24 assert trap for 1 cycle; run 2 idle edges; then assert mret.
  - Required: pc = 0x100, epc = 0x24; pc advances to 0x108; after mret pc = 0x24 and epc is unchanged.
- Priority and wrap:
  - Stimulus 1: trap + mret + jalr asserted together at pc = 0x30.
  - Required: trap path taken, epc = 0x30, pc = 0x100.
  - Stimulus 2: pc forced via branch to 0xFFFF_FFFC, then 1 idle edge.
  - Required: pc = 0x0.
- Async reset mid-operation:
  - Stimulus: assert reset between clock edges during a stalled redirect.
  - Required: pc = RESET_VECTOR, epc = 0 and redirect = 0 immediately (before the next edge); normal sequencing resumes after release.

Source files
------------

// File: rtl/pc_unit.sv
// Program-counter unit for the fetch stage.
// Selects the next PC by fixed priority (trap, mret, jalr, branch, stall, sequential),
// checks redirect targets for alignment, keeps the exception PC, and emits a one-cycle
// redirect pulse so fetch/decode can flush.
module pc_unit #(
    parameter int unsigned         WIDTH        = 32,
    parameter logic [WIDTH-1:0]    RESET_VECTOR = 32'h0000_0000,
    parameter logic [WIDTH-1:0]    TRAP_VECTOR  = 32'h0000_0100,
    parameter int unsigned         ALIGN_BITS   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jalr,
    input  logic [WIDTH-1:0] jalr_target,
    input  logic             trap,
    input  logic             mret,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_next_seq,
    output logic [WIDTH-1:0] epc,
    output logic             misaligned,
    output logic             redirect
);

    // Sequential step and the mask of offset bits that must be zero in a target.
    localparam logic [WIDTH-1:0] STEP       = WIDTH'(1) << ALIGN_BITS;
    localparam logic [WIDTH-1:0] ALIGN_MASK = STEP - WIDTH'(1);

    typedef enum logic [2:0] {
        SrcSeq,
        SrcHold,
        SrcTrap,
        SrcMret,
        SrcTarget,
        SrcMisalign
    } pc_src_e;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic             redirect_q, redirect_d;
    logic             misaligned_q, misaligned_d;

    logic [WIDTH-1:0] jalr_tgt;
    logic [WIDTH-1:0] target;
    logic             target_misaligned;
    pc_src_e          pc_src;

    // JALR clears bit 0 before use; jalr takes precedence over a simultaneous branch.
    always_comb begin
        jalr_tgt          = {jalr_target[WIDTH-1:1], 1'b0};
        target            = jalr ? jalr_tgt : branch_target;
        target_misaligned = |(target & ALIGN_MASK);
    end

    // Wrapping add: no carry-out is kept.
    assign pc_next_seq = pc_q + STEP;

    // Priority selection of the PC source for this edge.
    always_comb begin
        pc_src = SrcSeq;
        if (trap) begin
            pc_src = SrcTrap;
        end else if (mret) begin
            pc_src = SrcMret;
        end else if (jalr || branch_taken) begin
            pc_src = target_misaligned ? SrcMisalign : SrcTarget;
        end else if (stall) begin
            pc_src = SrcHold;
        end
    end

    // Next-state values for pc, epc and the one-cycle status pulses.
    always_comb begin
        pc_d         = pc_q;
        epc_d        = epc_q;
        redirect_d   = 1'b0;
        misaligned_d = 1'b0;
        unique case (pc_src)
            SrcSeq: begin
                pc_d = pc_next_seq;
            end
            SrcHold: begin
                pc_d = pc_q;
            end
            SrcTrap: begin
                epc_d      = pc_q;
                pc_d       = TRAP_VECTOR;
                redirect_d = 1'b1;
            end
            SrcMret: begin
                // epc is left untouched on return.
                pc_d       = epc_q;
                redirect_d = 1'b1;
            end
            SrcTarget: begin
                pc_d       = target;
                redirect_d = 1'b1;
            end
            SrcMisalign: begin
                epc_d        = pc_q;
                pc_d         = TRAP_VECTOR;
                misaligned_d = 1'b1;
                redirect_d   = 1'b1;
            end
            default: begin
                pc_d = pc_next_seq;
            end
        endcase
    end

    // State registers; reset dominates every other input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q         <= RESET_VECTOR;
            epc_q        <= '0;
            redirect_q   <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            epc_q        <= epc_d;
            redirect_q   <= redirect_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign pc         = pc_q;
    assign epc        = epc_q;
    assign redirect   = redirect_q;
    assign misaligned = misaligned_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed, table-driven bench for pc_unit with default parameters.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jalr;
    logic [31:0] jalr_target;
    logic        trap;
    logic        mret;
    logic [31:0] pc;
    logic [31:0] pc_next_seq;
    logic [31:0] epc;
    logic        misaligned;
    logic        redirect;

    int total = 0;
    int bad   = 0;

    pc_unit dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jalr         (jalr),
        .jalr_target  (jalr_target),
        .trap         (trap),
        .mret         (mret),
        .pc           (pc),
        .pc_next_seq  (pc_next_seq),
        .epc          (epc),
        .misaligned   (misaligned),
        .redirect     (redirect)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] br_tgt;
        logic        jalr;
        logic [31:0] jalr_tgt;
        logic        trap;
        logic        mret;
        logic [31:0] exp_pc;
        logic [31:0] exp_epc;
        logic        exp_red;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic b, input logic [31:0] bt, input logic j,
                       input logic [31:0] jt, input logic t, input logic m,
                       input logic [31:0] epc_exp, input logic [31:0] pc_exp,
                       input logic red_exp, input logic mis_exp);
        vec_t v;
        v.stall = s; v.br = b; v.br_tgt = bt; v.jalr = j; v.jalr_tgt = jt;
        v.trap = t; v.mret = m; v.exp_pc = pc_exp; v.exp_epc = epc_exp;
        v.exp_red = red_exp; v.exp_mis = mis_exp;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        stall = 0; branch_taken = 0; branch_target = '0; jalr = 0; jalr_target = '0;
        trap = 0; mret = 0;
    endtask

    task automatic check_all(input string tag, input logic [31:0] p, input logic [31:0] e,
                             input logic r, input logic m);
        check({tag, " pc"}, pc, p);
        check({tag, " epc"}, epc, e);
        check({tag, " redirect"}, 32'(redirect), 32'(r));
        check({tag, " misaligned"}, 32'(misaligned), 32'(m));
        check({tag, " pc_next_seq"}, pc_next_seq, p + 32'd4);
    endtask

    initial begin
        // Columns: stall br br_tgt jalr jalr_tgt trap mret | exp epc, exp pc, redirect, misaligned
        add(0, 0, 0,            0, 0,     0, 0,  32'h00, 32'h04,       0, 0);
        add(0, 0, 0,            0, 0,     0, 0,  32'h00, 32'h08,       0, 0);
        add(0, 0, 0,            0, 0,     0, 0,  32'h00, 32'h0C,       0, 0);
        add(0, 0, 0,            0, 0,     0, 0,  32'h00, 32'h10,       0, 0);
        add(1, 0, 0,            0, 0,     0, 0,  32'h00, 32'h10,       0, 0);
        add(1, 0, 0,            0, 0,     0, 0,  32'h00, 32'h10,       0, 0);
        add(1, 1, 32'h40,       0, 0,     0, 0,  32'h00, 32'h40,       1, 0);
        add(0, 0, 0,            0, 0,     0, 0,  32'h00, 32'h44,       0, 0);
        add(0, 0, 0,            1, 32'h81, 0, 0, 32'h00, 32'h80,       1, 0);
        add(0, 0, 0,            1, 32'h82, 0, 0, 32'h80, 32'h100,      1, 1);
        add(0, 0, 0,            0, 0,     0, 0,  32'h80, 32'h104,      0, 0);
        add(0, 1, 32'h24,       0, 0,     0, 0,  32'h80, 32'h24,       1, 0);
        add(0, 0, 0,            0, 0,     1, 0,  32'h24, 32'h100,      1, 0);
        add(0, 0, 0,            0, 0,     0, 0,  32'h24, 32'h104,      0, 0);
        add(0, 0, 0,            0, 0,     0, 0,  32'h24, 32'h108,      0, 0);
        add(0, 0, 0,            0, 0,     0, 1,  32'h24, 32'h24,       1, 0);
        add(0, 0, 0,            0, 0,     0, 0,  32'h24, 32'h28,       0, 0);
        add(0, 0, 0,            0, 0,     0, 0,  32'h24, 32'h2C,       0, 0);
        add(0, 0, 0,            0, 0,     0, 0,  32'h24, 32'h30,       0, 0);
        add(0, 0, 0,            1, 32'h200, 1, 1, 32'h30, 32'h100,     1, 0);
        add(0, 1, 32'hFFFF_FFFC, 0, 0,    0, 0,  32'h30, 32'hFFFF_FFFC, 1, 0);
        add(0, 0, 0,            0, 0,     0, 0,  32'h30, 32'h00,       0, 0);
        add(0, 1, 32'h42,       0, 0,     0, 0,  32'h00, 32'h100,      1, 1);
        add(0, 0, 0,            0, 0,     0, 1,  32'h00, 32'h00,       1, 0);
        add(0, 1, 32'h70,       1, 32'h60, 0, 0, 32'h00, 32'h60,       1, 0);
        add(1, 0, 0,            0, 0,     1, 0,  32'h60, 32'h100,      1, 0);
        add(1, 0, 0,            0, 0,     0, 1,  32'h60, 32'h60,       1, 0);

        // Reset state, held across a couple of edges.
        idle_inputs();
        reset = 1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all("reset", 32'h0, 32'h0, 0, 0);
        @(negedge clk);
        reset = 0;

        foreach (vecs[i]) begin
            stall         = vecs[i].stall;
            branch_taken  = vecs[i].br;
            branch_target = vecs[i].br_tgt;
            jalr          = vecs[i].jalr;
            jalr_target   = vecs[i].jalr_tgt;
            trap          = vecs[i].trap;
            mret          = vecs[i].mret;
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_epc,
                      vecs[i].exp_red, vecs[i].exp_mis);
            @(negedge clk);
        end

        // Async reset between edges while a stalled branch redirect is in flight.
        idle_inputs();
        stall = 1; branch_taken = 1; branch_target = 32'h80;
        @(posedge clk);
        #1;
        check_all("pre_areset", 32'h80, 32'h60, 1, 0);
        #2;
        reset = 1;
        #1;
        check_all("areset_immediate", 32'h0, 32'h0, 0, 0);
        @(posedge clk);
        #1;
        check_all("areset_held", 32'h0, 32'h0, 0, 0);
        @(negedge clk);
        reset = 0;
        idle_inputs();
        @(posedge clk);
        #1;
        check_all("post_areset1", 32'h4, 32'h0, 0, 0);
        @(posedge clk);
        #1;
        check_all("post_areset2", 32'h8, 32'h0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
